// File: rtl/pcie_bar0_pixel_packer.sv
// RGB565 pixel stream -> 128-bit BAR0 image words with byte enables, one frame per host ack.
// Optional build macro PIXEL_BYTE_SWAP_EN byte-swaps each pixel before packing.
//
// state  | meaning
// IDLE   | waiting for a valid sof pixel
// FILL   | packing pixels of the current frame into BAR0 words
// HOLD   | frame complete, pixels dropped until i_frame_ack
module pcie_bar0_pixel_packer #(
  parameter int ADDR_WIDTH  = 12,
  parameter int FRAME_WORDS = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_pix_vld,
  input  logic [15:0]           i_pix_data,
  input  logic                  i_pix_sof,
  input  logic                  i_pix_eof,
  input  logic                  i_frame_ack,
  output logic                  o_bar0_wr_en,
  output logic [ADDR_WIDTH-1:0] o_bar0_wr_addr,
  output logic [127:0]          o_bar0_wr_data,
  output logic [15:0]           o_bar0_wr_byte_en,
  output logic                  o_frame_done,
  output logic [ADDR_WIDTH:0]   o_frame_words,
  output logic                  o_busy,
  output logic                  o_ovf,
  output logic [15:0]           o_drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0] FRAME_CAP = (ADDR_WIDTH+1)'(FRAME_WORDS);

  state_t              state_q, state_d;
  logic [2:0]          lane_q;
  logic [127:0]        buf_q;
  logic [ADDR_WIDTH:0] addr_q;

  logic [15:0]         pix;
  logic                accept_sof, frame_pix, ovf_drop, hold_drop;
  logic                store, word_close, frame_end;
  logic [2:0]          lane;
  logic [ADDR_WIDTH:0] base_addr;
  logic [127:0]        base_buf, pack_word;
  logic [15:0]         be_mask;

`ifdef PIXEL_BYTE_SWAP_EN
  assign pix = {i_pix_data[7:0], i_pix_data[15:8]};
`else
  assign pix = i_pix_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (i_pix_vld && i_pix_sof) state_d = i_pix_eof ? S_HOLD : S_FILL;
      S_FILL: if (i_pix_vld && i_pix_eof) state_d = S_HOLD;
      S_HOLD: if (i_frame_ack)            state_d = S_IDLE;
      default:                            state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy     = (state_q == S_FILL) || (state_q == S_HOLD);
    accept_sof = i_pix_vld && i_pix_sof && ((state_q == S_IDLE) || (state_q == S_FILL));
    frame_pix  = i_pix_vld && !i_pix_sof && (state_q == S_FILL);
    // once the last word slot is used, every further in-frame pixel is an overflow drop
    ovf_drop   = frame_pix && (addr_q == FRAME_CAP);
    hold_drop  = i_pix_vld && (state_q == S_HOLD);
    store      = accept_sof || (frame_pix && !ovf_drop);
    frame_end  = i_pix_vld && i_pix_eof && (accept_sof || frame_pix);
    lane       = accept_sof ? 3'd0 : lane_q;
    base_addr  = accept_sof ? '0 : addr_q;
    base_buf   = accept_sof ? '0 : buf_q;
    word_close = store && ((lane == 3'd7) || i_pix_eof);
    pack_word  = '0;
    be_mask    = '0;
    for (int i = 0; i < 8; i++) begin
      pack_word[16*i +: 16] = (lane == 3'(i)) ? pix : base_buf[16*i +: 16];
      be_mask[2*i +: 2]     = (3'(i) <= lane) ? 2'b11 : 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q            <= '0;
      buf_q             <= '0;
      addr_q            <= '0;
      o_bar0_wr_en      <= 1'b0;
      o_bar0_wr_addr    <= '0;
      o_bar0_wr_data    <= '0;
      o_bar0_wr_byte_en <= '0;
      o_frame_done      <= 1'b0;
      o_frame_words     <= '0;
      o_ovf             <= 1'b0;
      o_drop_cnt        <= '0;
    end else begin
      o_bar0_wr_en <= word_close;
      o_frame_done <= frame_end;
      if (store) begin
        if (word_close) begin
          o_bar0_wr_addr    <= base_addr[ADDR_WIDTH-1:0];
          o_bar0_wr_data    <= pack_word;
          o_bar0_wr_byte_en <= be_mask;
          buf_q             <= '0;
          lane_q            <= '0;
          addr_q            <= base_addr + 1'b1;
        end else begin
          buf_q  <= pack_word;
          lane_q <= lane + 3'd1;
          addr_q <= base_addr;
        end
      end
      // an eof that was itself an overflow drop reports the full capacity
      if (frame_end) o_frame_words <= store ? (base_addr + 1'b1) : addr_q;
      if (accept_sof)    o_ovf <= 1'b0;
      else if (ovf_drop) o_ovf <= 1'b1;
      if ((ovf_drop || hold_drop) && (o_drop_cnt != 16'hFFFF))
        o_drop_cnt <= o_drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pcie_bar0_pixel_packer.sv
// Scoreboard bench for pcie_bar0_pixel_packer: directed test-plan frames plus randomized frames.
module tb_pcie_bar0_pixel_packer;
  localparam int AW = 12;
  localparam int FW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_vld = 1'b0;
  logic [15:0]   pix_data = '0;
  logic          pix_sof = 1'b0;
  logic          pix_eof = 1'b0;
  logic          frame_ack = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [127:0]  wr_data;
  logic [15:0]   wr_be;
  logic          frame_done;
  logic [AW:0]   frame_words;
  logic          busy;
  logic          ovf;
  logic [15:0]   drop_cnt;

  pcie_bar0_pixel_packer #(.ADDR_WIDTH(AW), .FRAME_WORDS(FW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_pix_vld(pix_vld), .i_pix_data(pix_data), .i_pix_sof(pix_sof), .i_pix_eof(pix_eof),
    .i_frame_ack(frame_ack),
    .o_bar0_wr_en(wr_en), .o_bar0_wr_addr(wr_addr), .o_bar0_wr_data(wr_data),
    .o_bar0_wr_byte_en(wr_be), .o_frame_done(frame_done), .o_frame_words(frame_words),
    .o_busy(busy), .o_ovf(ovf), .o_drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [127:0]  data;
    logic [15:0]   be;
    bit            done;
    logic [AW:0]   fw;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // reference model: frame = list of accepted pixels, words emitted in groups of 8
  localparam int M_IDLE = 0, M_FILL = 1, M_HOLD = 2;
  int          m_mode = M_IDLE;
  logic [15:0] cur[$];
  int          m_words = 0;
  int          m_drops = 0;
  bit          m_ovf = 0;

`ifdef PIXEL_BYTE_SWAP_EN
  localparam logic [15:0] ABCD_PACKED = 16'hCDAB;
`else
  localparam logic [15:0] ABCD_PACKED = 16'hABCD;
`endif

  function automatic logic [15:0] fmt(input logic [15:0] d);
`ifdef PIXEL_BYTE_SWAP_EN
    return {d[7:0], d[15:8]};
`else
    return d;
`endif
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_drop();
    if (m_drops < 65535) m_drops++;
  endfunction

  function automatic void model_add(input logic [15:0] d, input bit e);
    exp_t x;
    if (m_words == FW) begin
      model_drop();
      m_ovf = 1;
      if (e) begin
        x.wr = 0; x.addr = '0; x.data = '0; x.be = '0; x.done = 1; x.fw = (AW+1)'(FW);
        exp_q.push_back(x);
      end
    end else begin
      cur.push_back(d);
      if (cur.size() == 8 || e) begin
        x.wr   = 1;
        x.addr = AW'(m_words);
        x.data = '0;
        foreach (cur[i]) x.data[16*i +: 16] = fmt(cur[i]);
        x.be   = 16'((32'h1 << (2 * cur.size())) - 1);
        x.done = e;
        x.fw   = (AW+1)'(m_words + 1);
        exp_q.push_back(x);
        m_words++;
        cur.delete();
      end
    end
    if (e) m_mode = M_HOLD;
  endfunction

  function automatic void model_pix(input logic [15:0] d, input bit s, input bit e);
    if (m_mode == M_HOLD) begin
      model_drop();
    end else if (s) begin
      cur.delete();
      m_words = 0;
      m_ovf = 0;
      m_mode = M_FILL;
      model_add(d, e);
    end else if (m_mode == M_FILL) begin
      model_add(d, e);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n && (wr_en || frame_done)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: wr_en=%b done=%b addr=%h with nothing expected", wr_en, frame_done, wr_addr);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        check("wr_en", 128'(wr_en), 128'(x.wr));
        if (x.wr) begin
          check("wr_addr", 128'(wr_addr), 128'(x.addr));
          check("wr_data", wr_data, x.data);
          check("wr_byte_en", 128'(wr_be), 128'(x.be));
        end
        check("frame_done", 128'(frame_done), 128'(x.done));
        if (x.done) check("frame_words", 128'(frame_words), 128'(x.fw));
      end
    end
  end

  task automatic send(input logic [15:0] d, input bit s, input bit e);
    model_pix(d, s, e);
    pix_vld = 1'b1; pix_data = d; pix_sof = s; pix_eof = e;
    @(posedge clk); #1;
    pix_vld = 1'b0; pix_sof = 1'b0; pix_eof = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [15:0] first, input bit with_eof);
    for (int i = 0; i < n; i++)
      send(first + 16'(i), i == 0, with_eof && (i == n - 1));
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    @(posedge clk); #1;
    frame_ack = 1'b0;
    if (m_mode == M_HOLD) m_mode = M_IDLE;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin @(posedge clk); #1; k++; end
    repeat (2) begin @(posedge clk); #1; end
    check("drain_pending", 128'(exp_q.size()), 128'(0));
    exp_q.delete();
  endtask

  task automatic status();
    @(negedge clk);
    check("busy", 128'(busy), 128'(m_mode != M_IDLE));
    check("ovf", 128'(ovf), 128'(m_ovf));
    check("drop_cnt", 128'(drop_cnt), 128'(m_drops));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, 128'(wr_en), 128'(0));
    check({tag, "_wr_addr"}, 128'(wr_addr), 128'(0));
    check({tag, "_wr_data"}, wr_data, 128'(0));
    check({tag, "_wr_be"}, 128'(wr_be), 128'(0));
    check({tag, "_done"}, 128'(frame_done), 128'(0));
    check({tag, "_frame_words"}, 128'(frame_words), 128'(0));
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_ovf"}, 128'(ovf), 128'(0));
    check({tag, "_drop_cnt"}, 128'(drop_cnt), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 16 pixels -> two full words
    send_frame(16, 16'h0001, 1);
    drain();
    check("t1_frame_words", 128'(frame_words), 128'(2));
    check("t1_last_addr", 128'(wr_addr), 128'(1));
    check("t1_last_be", 128'(wr_be), 128'(16'hFFFF));
    status();

    for (int i = 0; i < 5; i++) send(16'h5000 + 16'(i), 0, 0);
    check("hold_drops", 128'(drop_cnt), 128'(5));
    ack();
    status();

    // 11 pixels -> partial second word
    send_frame(11, 16'h1100, 1);
    drain();
    check("t2_be", 128'(wr_be), 128'(16'h003F));
    check("t2_upper_zero", 128'(wr_data[127:48]), 128'(0));
    check("t2_frame_words", 128'(frame_words), 128'(2));
    ack();

    send(16'hABCD, 1, 1);
    drain();
    check("t3_data", 128'(wr_data[15:0]), 128'(ABCD_PACKED));
    check("t3_be", 128'(wr_be), 128'(16'h0003));
    check("t3_addr", 128'(wr_addr), 128'(0));
    status();
    ack();

    // overflow: 20 pixels into a 2-word frame
    send_frame(20, 16'h2000, 1);
    drain();
    check("ovf_set", 128'(ovf), 128'(1));
    check("ovf_frame_words", 128'(frame_words), 128'(2));
    check("ovf_drops", 128'(drop_cnt), 128'(9));
    ack();
    send(16'h3000, 1, 0);
    check("ovf_cleared", 128'(ovf), 128'(0));
    send(16'h3001, 0, 0);
    send(16'h3002, 0, 1);
    drain();
    status();
    ack();

    // abort after 12 pixels, ack outside HOLD ignored
    send_frame(12, 16'h4000, 0);
    ack();
    send_frame(8, 16'h4100, 1);
    drain();
    check("abort_frame_words", 128'(frame_words), 128'(1));
    check("abort_drops", 128'(drop_cnt), 128'(9));
    status();
    ack();
    ack();
    status();

    for (int f = 0; f < 30; f++) begin
      int n;
      n = $urandom_range(1, 22);
      for (int i = 0; i < n; i++) begin
        bit s;
        s = (i == 0) || ($urandom_range(0, 30) == 0);
        send(16'($urandom), s, i == n - 1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        if (i != n - 1 && $urandom_range(0, 10) == 0) ack();
      end
      for (int i = $urandom_range(0, 3); i > 0; i--) send(16'($urandom), $urandom_range(0, 1) == 1, 0);
      drain();
      status();
      ack();
    end

    // reset mid-frame
    send_frame(10, 16'h6000, 0);
    drain();
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    m_mode = M_IDLE; m_drops = 0; m_ovf = 0; cur.delete(); m_words = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'h7777, 0, 1);
    send_frame(3, 16'h7000, 1);
    drain();
    check("post_rst_addr", 128'(wr_addr), 128'(0));
    check("post_rst_be", 128'(wr_be), 128'(16'h003F));
    status();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
